// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg: shared constants, state type and helpers for the Feistel cipher.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cipher_pkg;

   localparam int NW          = 9;
   localparam int NROUNDS     = 31;
   localparam int ROUND_FIRST = 92;
   localparam int ROUND_LAST  = 2;
   localparam int ROUND_STEP  = 3;
   localparam int KEY_W       = 144;
   localparam int NKW         = KEY_W / NW;     // master-key words held in W
   localparam int NWORDS      = 3 * NROUNDS;    // schedule words written by expansion

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EXPAND = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Rotate-left of a word: the upper half of {x,x} shifted holds the rotation.
   function automatic logic [NW-1:0] rotl9(input logic [NW-1:0] x, input int unsigned n);
      logic [2*NW-1:0] d;
      d = {x, x} << (n % NW);
      return d[2*NW-1 -: NW];
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_buf.sv
// ---------------------------------------------------------------------------
// key_buf: 31 x 27-bit round-key store, one word write port, one comb read port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_buf
   import cipher_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [4:0]    wr_slot,
   input  logic [1:0]    wr_lane,
   input  logic [NW-1:0] wr_word,
   input  logic [4:0]    rd_idx,
   output logic [NW-1:0] rd_key_1,
   output logic [NW-1:0] rd_key_2,
   output logic [NW-1:0] rd_key_3
);

   logic [3*NW-1:0] slots [NROUNDS];
   logic [3*NW-1:0] rd_data;

   // Lane 0 (key 1) sits in the low word of each slot.
   genvar s;
   generate
      for (s = 0; s < NROUNDS; s++) begin : g_slot
         logic [3*NW-1:0] q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else if (we && (wr_slot == 5'(s))) begin
               case (wr_lane)
                  2'd0:    q[NW-1:0]      <= wr_word;
                  2'd1:    q[2*NW-1:NW]   <= wr_word;
                  2'd2:    q[3*NW-1:2*NW] <= wr_word;
                  default: ;
               endcase
            end
         end

         assign slots[s] = q;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (rd_idx < 5'(NROUNDS))
         rd_data = slots[rd_idx];
   end

   assign rd_key_1 = rd_data[NW-1:0];
   assign rd_key_2 = rd_data[2*NW-1:NW];
   assign rd_key_3 = rd_data[3*NW-1:2*NW];

endmodule

`default_nettype wire

// File: rtl/key_sched.sv
// ---------------------------------------------------------------------------
// key_sched: expands a 144-bit master key into 31 round-key triples and serves
// them combinationally by round number. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_sched
   import cipher_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   input  logic [KEY_W-1:0] key_in,
   input  logic [6:0]       round_no,
   output logic [NW-1:0]    round_key_1,
   output logic [NW-1:0]    round_key_2,
   output logic [NW-1:0]    round_key_3,
   output logic             busy,
   output logic             ready,
   output logic             key_err
);

   state_t        state;
   state_t        state_nx;
   logic [NW-1:0] w [NKW];
   logic [6:0]    t;
   logic [4:0]    r;
   logic [1:0]    l;
   logic          step;
   logic [4:0]    rd_idx;
   logic [NW-1:0] buf_k1;
   logic [NW-1:0] buf_k2;
   logic [NW-1:0] buf_k3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // A load strobe restarts from any state, including mid-expansion.
   always_comb begin
      state_nx = state;
      if (key_load) begin
         state_nx = ST_LOAD;
      end else begin
         case (state)
            ST_IDLE:   state_nx = ST_IDLE;
            ST_LOAD:   state_nx = ST_EXPAND;
            ST_EXPAND: if (t == 7'(NWORDS - 1)) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_DONE;
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy  = (state == ST_LOAD) || (state == ST_EXPAND);
      ready = (state == ST_DONE);
      step  = busy && !key_load;
   end

   // W is loaded on the key_load edge itself so that word 0 lands on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NKW; i++)
            w[i] <= '0;
         t <= '0;
         r <= '0;
         l <= '0;
      end else if (key_load) begin
         for (int i = 0; i < NKW; i++)
            w[i] <= key_in[KEY_W-1-NW*i -: NW];
         t <= '0;
         r <= '0;
         l <= '0;
      end else if (step) begin
         for (int i = 0; i < NKW - 1; i++)
            w[i] <= w[i+1];
         w[NKW-1] <= w[0] ^ rotl9(w[9], 3) ^ {2'b00, t};
         t <= t + 7'd1;
         if (l == 2'd2) begin
            l <= 2'd0;
            r <= r + 5'd1;
         end else begin
            l <= l + 2'd1;
         end
      end
   end

   key_buf u_key_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (step),
      .wr_slot  (r),
      .wr_lane  (l),
      .wr_word  (w[0]),
      .rd_idx   (rd_idx),
      .rd_key_1 (buf_k1),
      .rd_key_2 (buf_k2),
      .rd_key_3 (buf_k3)
   );

   // round_no -> round index; only 2, 5, ..., 92 are valid.
   always_comb begin
      rd_idx  = '0;
      key_err = 1'b0;
      case (round_no)
         7'd2:    rd_idx = 5'd0;
         7'd5:    rd_idx = 5'd1;
         7'd8:    rd_idx = 5'd2;
         7'd11:   rd_idx = 5'd3;
         7'd14:   rd_idx = 5'd4;
         7'd17:   rd_idx = 5'd5;
         7'd20:   rd_idx = 5'd6;
         7'd23:   rd_idx = 5'd7;
         7'd26:   rd_idx = 5'd8;
         7'd29:   rd_idx = 5'd9;
         7'd32:   rd_idx = 5'd10;
         7'd35:   rd_idx = 5'd11;
         7'd38:   rd_idx = 5'd12;
         7'd41:   rd_idx = 5'd13;
         7'd44:   rd_idx = 5'd14;
         7'd47:   rd_idx = 5'd15;
         7'd50:   rd_idx = 5'd16;
         7'd53:   rd_idx = 5'd17;
         7'd56:   rd_idx = 5'd18;
         7'd59:   rd_idx = 5'd19;
         7'd62:   rd_idx = 5'd20;
         7'd65:   rd_idx = 5'd21;
         7'd68:   rd_idx = 5'd22;
         7'd71:   rd_idx = 5'd23;
         7'd74:   rd_idx = 5'd24;
         7'd77:   rd_idx = 5'd25;
         7'd80:   rd_idx = 5'd26;
         7'd83:   rd_idx = 5'd27;
         7'd86:   rd_idx = 5'd28;
         7'd89:   rd_idx = 5'd29;
         7'd92:   rd_idx = 5'd30;
         default: key_err = 1'b1;
      endcase
   end

   always_comb begin
      round_key_1 = key_err ? '0 : buf_k1;
      round_key_2 = key_err ? '0 : buf_k2;
      round_key_3 = key_err ? '0 : buf_k3;
   end

endmodule

`default_nettype wire

// File: tb/tb_key_sched.sv
// ---------------------------------------------------------------------------
// tb_key_sched: directed + random checks of key_sched against a word-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_load;
   logic [143:0] key_in;
   logic [6:0]   round_no;
   logic [8:0]   round_key_1;
   logic [8:0]   round_key_2;
   logic [8:0]   round_key_3;
   logic         busy;
   logic         ready;
   logic         key_err;

   int           n_assert = 0;
   int           n_fail   = 0;
   int           lat;
   logic [8:0]   mw [93];

   always #5 clk = ~clk;

   key_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_load    (key_load),
      .key_in      (key_in),
      .round_no    (round_no),
      .round_key_1 (round_key_1),
      .round_key_2 (round_key_2),
      .round_key_3 (round_key_3),
      .busy        (busy),
      .ready       (ready),
      .key_err     (key_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [8:0] rotl3(input logic [8:0] x);
      int v;
      v = int'(x);
      v = ((v * 8) + (v / 64)) % 512;
      return 9'(v);
   endfunction

   // word n: n<16 from the key; otherwise w[n-16] ^ rotl3(w[n-7]) ^ (n-16)
   task automatic build_model(input logic [143:0] key);
      for (int n = 0; n < 16; n++)
         mw[n] = key[143-9*n -: 9];
      for (int n = 16; n < 93; n++)
         mw[n] = mw[n-16] ^ rotl3(mw[n-7]) ^ 9'(n - 16);
   endtask

   task automatic clear_model();
      for (int n = 0; n < 93; n++)
         mw[n] = '0;
   endtask

   task automatic check_read(input int rn, input string tag);
      int         k;
      logic [27:0] expv;
      round_no = 7'(rn);
      #1;
      if (rn >= 2 && rn <= 92 && ((rn - 2) % 3) == 0) begin
         k    = (rn - 2) / 3;
         expv = {mw[3*k], mw[3*k+1], mw[3*k+2], 1'b0};
      end else begin
         expv = {27'd0, 1'b1};
      end
      chk($sformatf("%s rn=%0d", tag, rn), {round_key_1, round_key_2, round_key_3, key_err}, expv);
   endtask

   task automatic check_all(input string tag);
      for (int rn = 0; rn < 96; rn++)
         check_read(rn, tag);
      check_read(127, tag);
   endtask

   task automatic do_load(input logic [143:0] k);
      @(negedge clk);
      key_in   = k;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      lat      = 0;
   endtask

   task automatic wait_ready(input string tag);
      while (!ready && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd93);
   endtask

   function automatic logic [143:0] rand_key();
      logic [159:0] v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return v[143:0];
   endfunction

   logic [143:0] key_a;
   logic [143:0] key_b;
   logic         ready_seen;

   initial begin
      rst_n    = 1'b0;
      key_load = 1'b0;
      key_in   = '0;
      round_no = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset ready", 64'(ready), 64'd0);
      clear_model();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("post-reset");

      // all-zero key
      do_load('0);
      chk("zero busy after load", 64'(busy), 64'd1);
      chk("zero ready after load", 64'(ready), 64'd0);
      wait_ready("zero");
      chk("zero busy done", 64'(busy), 64'd0);
      round_no = 7'd2;  #1;
      chk("zero rn2", {round_key_1, round_key_2, round_key_3}, {9'h000, 9'h000, 9'h000});
      round_no = 7'd17; #1;
      chk("zero rn17", {round_key_1, round_key_2, round_key_3}, {9'h000, 9'h000, 9'h001});
      build_model('0);
      check_all("zero");

      // W[0] = 0x1FF
      do_load({9'h1FF, 135'd0});
      wait_ready("w0");
      round_no = 7'd2;  #1;
      chk("w0 rn2", {round_key_1, round_key_2, round_key_3}, {9'h1FF, 9'h000, 9'h000});
      round_no = 7'd17; #1;
      chk("w0 rn17", {round_key_1, round_key_2, round_key_3}, {9'h000, 9'h1FF, 9'h001});
      foreach (mw[i]) mw[i] = '0;
      build_model({9'h1FF, 135'd0});
      check_all("w0");

      // invalid round numbers
      round_no = 7'd0;  #1; chk("inv 0",  {round_key_1, round_key_2, round_key_3, key_err}, {27'd0, 1'b1});
      round_no = 7'd3;  #1; chk("inv 3",  {round_key_1, round_key_2, round_key_3, key_err}, {27'd0, 1'b1});
      round_no = 7'd93; #1; chk("inv 93", {round_key_1, round_key_2, round_key_3, key_err}, {27'd0, 1'b1});
      round_no = 7'd95; #1; chk("inv 95", {round_key_1, round_key_2, round_key_3, key_err}, {27'd0, 1'b1});
      round_no = 7'd92; #1; chk("valid 92 err", 64'(key_err), 64'd0);

      // random keys
      for (int n = 0; n < 3; n++) begin
         key_a = rand_key();
         do_load(key_a);
         wait_ready($sformatf("rand%0d", n));
         build_model(key_a);
         check_all($sformatf("rand%0d", n));
         for (int j = 0; j < 8; j++)
            check_read(int'($urandom_range(127, 0)), $sformatf("rand%0d rr", n));
      end

      // restart mid-expansion
      key_a      = rand_key();
      key_b      = rand_key();
      ready_seen = 1'b0;
      do_load(key_a);
      repeat (39) begin
         @(negedge clk);
         ready_seen = ready_seen | ready;
      end
      do_load(key_b);
      build_model(key_b);
      ready_seen = ready_seen | ready;
      repeat (10) begin
         @(negedge clk);
         lat++;
         ready_seen = ready_seen | ready;
      end
      chk("restart ready low", 64'(ready_seen), 64'd0);
      chk("restart busy", 64'(busy), 64'd1);
      check_read(2, "restart early slot");
      wait_ready("restart");
      check_all("restart");

      // reset mid-expansion
      do_load(rand_key());
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst ready", 64'(ready), 64'd0);
      clear_model();
      check_all("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst stays idle", {62'd0, busy, ready}, 64'd0);
      key_a = rand_key();
      do_load(key_a);
      wait_ready("after rst");
      build_model(key_a);
      check_all("after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
